// File: rtl/scale_up.sv
// 2x image upscaler: pulls an IN_W x IN_H raster through ask, emits 2*IN_W x 2*IN_H on out/display.
// Each row is fetched once, interpolated horizontally, then replayed from the line buffer for the odd output row.
module scale_up #(
  parameter int IN_W = 64,
  parameter int IN_H = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in,
  output logic [7:0] out,
  output logic       display,
  output logic       ask
);

  localparam int CW = $clog2(IN_W);
  localparam int KW = CW + 1;
  localparam int RW = (IN_H > 1) ? $clog2(IN_H) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, EVEN, ODD, REPEAT, DONE} state_t;

  state_t         state, state_nxt;
  logic [RW-1:0]  r;
  logic [CW-1:0]  c;
  logic [KW-1:0]  k;
  logic [7:0]     cur, nxt, held, pix;
  logic [7:0]     lb [IN_W];
  logic           last_col, last_k, last_row;
  logic [CW-1:0]  rd_idx, rd_idx_p1;

  function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return s[8:1];
  endfunction

  assign last_col  = (c == CW'(IN_W - 1));
  assign last_k    = (k == KW'(2 * IN_W - 1));
  assign last_row  = (r == RW'(IN_H - 1));
  assign rd_idx    = k[KW-1:1];
  // At the final odd k the right neighbour does not exist; keep the index in range.
  assign rd_idx_p1 = last_k ? rd_idx : rd_idx + CW'(1);

  always_comb begin
    state_nxt = state;
    ask       = 1'b0;
    display   = 1'b0;
    pix       = held;
    case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: begin
        ask       = 1'b1;
        state_nxt = EVEN;
      end
      EVEN: begin
        display   = 1'b1;
        pix       = cur;
        ask       = !last_col;
        state_nxt = ODD;
      end
      ODD: begin
        display   = 1'b1;
        pix       = last_col ? cur : avg(cur, nxt);
        state_nxt = last_col ? REPEAT : EVEN;
      end
      REPEAT: begin
        display = 1'b1;
        if (!k[0])
          pix = lb[rd_idx];
        else if (last_k)
          pix = lb[IN_W-1];
        else
          pix = avg(lb[rd_idx], lb[rd_idx_p1]);
        if (last_k)
          state_nxt = last_row ? DONE : FETCH;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  assign out = display ? pix : held;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      r     <= '0;
      c     <= '0;
      k     <= '0;
      cur   <= '0;
      nxt   <= '0;
      held  <= '0;
    end else begin
      state <= state_nxt;
      if (display)
        held <= pix;
      case (state)
        FETCH: begin
          cur <= in;
          c   <= '0;
        end
        EVEN: if (!last_col) nxt <= in;
        ODD: begin
          cur <= nxt;
          c   <= c + CW'(1);
          if (last_col)
            k <= '0;
        end
        REPEAT: begin
          k <= k + KW'(1);
          if (last_k && !last_row)
            r <= r + RW'(1);
        end
        default: ;
      endcase
    end
  end

  // Line buffer needs no reset: each entry is rewritten before REPEAT reads it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == FETCH)
        lb[0] <= in;
      else if (state == EVEN && !last_col)
        lb[c + CW'(1)] <= in;
    end
  end

endmodule

// File: tb/tb_scale_up.sv
// Bench for scale_up: random and patterned frames, scoreboard of expected output pixels, cycle schedule checks.
module tb_scale_up;

  localparam int W     = 64;
  localparam int H     = 64;
  localparam int OW    = 2 * W;
  localparam int ROWC  = 4 * W + 1;
  localparam int FRAME = H * ROWC;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in = 8'd0;
  logic [7:0] out;
  logic       display;
  logic       ask;

  scale_up #(.IN_W(W), .IN_H(H)) dut (
    .clk(clk), .reset(reset), .in(in), .out(out), .display(display), .ask(ask)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [7:0] img [H*W];
  logic [7:0] exp_q [$];
  logic [7:0] got [4*W*H];
  int         in_idx = 0;
  int         t = 0;
  int         ask_cnt = 0;
  int         disp_cnt = 0;
  int         sched_err = 0;
  bit         rst_q = 1'b0;
  bit         frame_done = 1'b0;
  logic [7:0] last_out = 8'd0;
  int         pos, col;
  bit         e_ask, e_disp;
  logic [7:0] e;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Source: presents the next raster pixel in every ask cycle, junk otherwise.
  always @(negedge clk) begin
    if (reset)
      in_idx = 0;
    else if (ask === 1'b1) begin
      in = (in_idx < H * W) ? img[in_idx] : 8'($urandom);
      in_idx++;
    end else
      in = 8'($urandom);
  end

  always @(posedge clk) rst_q = reset;

  // Monitor: reset outputs, per-cycle ask/display schedule, scoreboard pixels, DONE hold.
  always @(negedge clk) begin
    if (rst_q) begin
      check("reset_ask", {15'd0, ask}, 16'd0);
      check("reset_display", {15'd0, display}, 16'd0);
      check("reset_out", {8'd0, out}, 16'd0);
      t = 0; ask_cnt = 0; disp_cnt = 0; sched_err = 0;
      frame_done = 1'b0; last_out = 8'd0;
    end else if (t < FRAME) begin
      pos    = t % ROWC;
      e_disp = (pos != 0);
      e_ask  = (pos == 0) || (pos <= OW && ((pos - 1) % 2 == 0) && ((pos - 1) / 2 < W - 1));
      if (ask !== e_ask || display !== e_disp) sched_err++;
      if (ask === 1'b1) ask_cnt++;
      if (display === 1'b1) begin
        if (exp_q.size() == 0)
          check("scoreboard_underflow", 16'd1, 16'd0);
        else begin
          e = exp_q.pop_front();
          if (disp_cnt < 4 * W * H) got[disp_cnt] = out;
          if (bad < 40)
            check($sformatf("pixel[%0d]", disp_cnt), {8'd0, out}, {8'd0, e});
          last_out = e;
        end
        disp_cnt++;
      end
      t++;
      if (t == FRAME) begin
        check("schedule_errors", 16'(sched_err), 16'd0);
        check("ask_count", 16'(ask_cnt), 16'(W * H));
        check("display_count", 16'(disp_cnt), 16'(4 * W * H));
        check("queue_left", 16'(exp_q.size()), 16'd0);
        frame_done = 1'b1;
      end
    end else begin
      check("done_ask", {15'd0, ask}, 16'd0);
      check("done_display", {15'd0, display}, 16'd0);
      check("done_out_hold", {8'd0, out}, {8'd0, last_out});
    end
  end

  // Reference: even output columns copy the source, odd ones average right neighbour; rows doubled.
  task automatic build_expected();
    int a, b;
    exp_q.delete();
    for (int r = 0; r < H; r++)
      for (int rep = 0; rep < 2; rep++)
        for (int x = 0; x < OW; x++) begin
          a = int'(img[r*W + x/2]);
          if (x % 2 == 0 || x / 2 == W - 1)
            exp_q.push_back(8'(a));
          else begin
            b = int'(img[r*W + x/2 + 1]);
            exp_q.push_back(8'((a + b + 1) / 2));
          end
        end
  endtask

  task automatic start_frame(input int mode);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < H * W; i++)
      img[i] = (mode == 1) ? 8'h80 : 8'($urandom);
    if (mode == 0) begin
      img[0] = 8'd10; img[1] = 8'd13; img[2] = 8'd20;
      img[W + 62] = 8'd100; img[W + 63] = 8'd200;
      img[2*W + 4] = 8'd255; img[2*W + 5] = 8'd255;
      img[2*W + 6] = 8'd0;   img[2*W + 7] = 8'd1;
    end
    build_expected();
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!frame_done && n < FRAME + 50) begin
      @(posedge clk);
      n++;
    end
    check("frame_completes", {15'd0, frame_done}, 16'd1);
    repeat (4) @(posedge clk);
  endtask

  int idx_tab [14];
  int val_tab [14];

  initial begin
    idx_tab = '{0, 1, 2, 3, 4, OW, OW+3, 2*OW+124, 2*OW+125, 2*OW+126, 2*OW+127, 3*OW+125, 4*OW+9, 4*OW+13};
    val_tab = '{10, 12, 13, 17, 20, 10, 17, 100, 150, 200, 200, 150, 255, 1};

    start_frame(0);
    wait_done();
    for (int i = 0; i < 14; i++)
      check($sformatf("pattern_out[%0d]", idx_tab[i]), {8'd0, got[idx_tab[i]]}, 16'(val_tab[i]));

    start_frame(1);
    wait_done();

    start_frame(0);
    begin
      int n = 0;
      while (disp_cnt < 5 * 4 * W + OW + 3 && n < FRAME) begin
        @(posedge clk);
        n++;
      end
      check("reached_row5_repeat", {15'd0, (disp_cnt >= 5 * 4 * W + OW + 3)}, 16'd1);
    end

    start_frame(0);
    wait_done();
    check("restart_first_pixel", {8'd0, got[0]}, 16'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
